// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared state encoding and constants for the instruction fetch controller
package fetch_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

    localparam logic [31:0] TEXT_BASE_DEFAULT = 32'h0040_0000;
    localparam logic [31:0] WORD_BYTES        = 32'd4;
endpackage

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - 2-entry FIFO of {instr, pc} between fetch and decode
module fetch_buffer #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] push_instr,
    input  logic [DATA_WIDTH-1:0] push_pc,
    output logic [1:0]            count,
    output logic                  head_valid,
    output logic [DATA_WIDTH-1:0] head_instr,
    output logic [DATA_WIDTH-1:0] head_pc
);
    logic [DATA_WIDTH-1:0] instr_mem [2];
    logic [DATA_WIDTH-1:0] pc_mem    [2];
    logic                  wr_ptr;
    logic                  rd_ptr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count        <= 2'd0;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            instr_mem[0] <= '0;
            instr_mem[1] <= '0;
            pc_mem[0]    <= '0;
            pc_mem[1]    <= '0;
        end else if (flush) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) begin
                instr_mem[wr_ptr] <= push_instr;
                pc_mem[wr_ptr]    <= push_pc;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Head is forced to zero when empty so decode never sees stale words.
    assign head_valid = (count != 2'd0);
    assign head_instr = head_valid ? instr_mem[rd_ptr] : '0;
    assign head_pc    = head_valid ? pc_mem[rd_ptr]    : '0;
endmodule

// File: rtl/instruction_fetch_controller.sv
// rtl/instruction_fetch_controller.sv - fetch PC, ROM addressing, legality check and decode buffer
module instruction_fetch_controller
    import fetch_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] TEXT_BASE    = TEXT_BASE_DEFAULT,
    parameter int                    MEMORY_DEPTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable_i,
    input  logic                  redirect_i,
    input  logic [DATA_WIDTH-1:0] redirect_target_i,
    output logic [DATA_WIDTH-1:0] imem_address_o,
    input  logic [DATA_WIDTH-1:0] imem_instruction_i,
    output logic                  instr_valid_o,
    input  logic                  instr_ready_i,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [DATA_WIDTH-1:0] pc_o,
    output logic                  fault_o
);
    // One extra bit so the upper bound cannot wrap near the top of the address space.
    localparam logic [DATA_WIDTH:0] TEXT_LIMIT =
        {1'b0, TEXT_BASE} + (DATA_WIDTH+1)'(WORD_BYTES * MEMORY_DEPTH);

    fetch_state_t          state, state_next;
    logic [DATA_WIDTH-1:0] fetch_pc, pc_next;
    logic                  legal;
    logic                  push, pop, flush;
    logic [1:0]            count;

    assign legal = (fetch_pc[1:0] == 2'b00) && (fetch_pc >= TEXT_BASE) &&
                   ({1'b0, fetch_pc} < TEXT_LIMIT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            fetch_pc <= TEXT_BASE;
        end else begin
            state    <= state_next;
            fetch_pc <= pc_next;
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = fetch_pc;
        push       = 1'b0;
        flush      = 1'b0;
        pop        = instr_valid_o & instr_ready_i;
        case (state)
            IDLE: begin
                if (enable_i) state_next = FETCH;
            end
            FETCH, HALT: begin
                if (redirect_i) begin
                    flush      = 1'b1;
                    pop        = 1'b0;
                    pc_next    = redirect_target_i;
                    state_next = FETCH;
                end else if (state == FETCH) begin
                    if (!legal) begin
                        state_next = HALT;
                    end else if (enable_i && (count != 2'd2 || pop)) begin
                        push    = 1'b1;
                        pc_next = fetch_pc + DATA_WIDTH'(WORD_BYTES);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    fetch_buffer #(.DATA_WIDTH(DATA_WIDTH)) u_buffer (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .pop        (pop),
        .flush      (flush),
        .push_instr (imem_instruction_i),
        .push_pc    (fetch_pc),
        .count      (count),
        .head_valid (instr_valid_o),
        .head_instr (instr_o),
        .head_pc    (pc_o)
    );

    assign imem_address_o = fetch_pc;
    assign fault_o        = (state == HALT);
endmodule
